// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous serial receiver.
//
// Recovers 8N1 / 8E1 / 8O1 frames: a start bit, 8 data bits LSB first, an optional
// parity bit and one stop bit. Each bit is sampled three times around its middle
// and resolved by a 2-of-3 majority vote. Each error-free byte is presented on P_DATA
// together with a one-cycle data_valid pulse.
//
// Ports:
//   CLK        oversampling clock, Prescale cycles per bit
//   RST        asynchronous active-low reset
//   Prescale   clocks per bit (even, 8..32)
//   RX_IN      serial line, idles high
//   PAR_EN     1: a parity bit follows the data bits
//   PAR_TYP    0: even parity, 1: odd parity
//   P_DATA     last byte received without error
//   data_valid one-cycle pulse when P_DATA is updated
module uart_rx #(
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [7:0]                P_DATA,
    output logic                      data_valid
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t                      state_q;
    logic [PRESCALE_WIDTH-1:0]   edge_cnt_q;
    logic [2:0]                  bit_cnt_q;
    logic [7:0]                  shift_q;
    logic [2:0]                  samples_q;
    logic                        par_err_q;
    logic                        stop_err_q;

    logic [PRESCALE_WIDTH-1:0]   half;
    logic [PRESCALE_WIDTH-1:0]   smp_lo;
    logic [PRESCALE_WIDTH-1:0]   smp_mid;
    logic [PRESCALE_WIDTH-1:0]   smp_hi;
    logic [PRESCALE_WIDTH-1:0]   dec_pt;
    logic [PRESCALE_WIDTH-1:0]   exit_pt;
    logic                        bit_end;
    logic                        is_dec;
    logic                        majority;
    logic                        par_exp;

    always_comb begin
        half     = Prescale >> 1;
        smp_lo   = half - PRESCALE_WIDTH'(1);
        smp_mid  = half;
        smp_hi   = half + PRESCALE_WIDTH'(1);
        dec_pt   = half + PRESCALE_WIDTH'(2);
        exit_pt  = half + PRESCALE_WIDTH'(3);
        bit_end  = (edge_cnt_q == (Prescale - PRESCALE_WIDTH'(1)));
        is_dec   = (edge_cnt_q == dec_pt);
        majority = (samples_q[0] & samples_q[1]) | (samples_q[0] & samples_q[2]) |
                   (samples_q[1] & samples_q[2]);
        par_exp  = PAR_TYP ? ~(^shift_q) : ^shift_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            samples_q  <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            if (state_q != StIdle) begin
                if (edge_cnt_q == smp_lo)  samples_q[0] <= RX_IN;
                if (edge_cnt_q == smp_mid) samples_q[1] <= RX_IN;
                if (edge_cnt_q == smp_hi)  samples_q[2] <= RX_IN;
                edge_cnt_q <= bit_end ? '0 : edge_cnt_q + PRESCALE_WIDTH'(1);
            end

            unique case (state_q)
                StIdle: begin
                    edge_cnt_q <= '0;
                    if (!RX_IN) begin
                        // The cycle that sees the falling edge is count 0 of the start bit.
                        state_q    <= StStart;
                        edge_cnt_q <= PRESCALE_WIDTH'(1);
                        par_err_q  <= 1'b0;
                        stop_err_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (is_dec && majority) begin
                        // Start bit did not hold low: treat as a glitch.
                        state_q    <= StIdle;
                        edge_cnt_q <= '0;
                    end else if (bit_end) begin
                        state_q   <= StData;
                        bit_cnt_q <= '0;
                    end
                end
                StData: begin
                    if (is_dec) shift_q <= {majority, shift_q[7:1]};
                    if (bit_end) begin
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PAR_EN ? StParity : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                StParity: begin
                    if (is_dec) par_err_q <= (majority != par_exp);
                    if (bit_end) state_q <= StStop;
                end
                StStop: begin
                    if (is_dec) begin
                        stop_err_q <= ~majority;
                        if (!par_err_q && majority) begin
                            P_DATA     <= shift_q;
                            data_valid <= 1'b1;
                        end
                    end else if (edge_cnt_q == exit_pt) begin
                        // Leave mid-stop-bit so a following start bit is never missed.
                        if (!RX_IN) begin
                            state_q    <= StStart;
                            edge_cnt_q <= PRESCALE_WIDTH'(1);
                            par_err_q  <= 1'b0;
                            stop_err_q <= 1'b0;
                        end else begin
                            state_q    <= StIdle;
                            edge_cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    edge_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
//
// Frames are built bit by bit from the byte and the parity rule, driven 2 ns after the
// rising clock edge, and the response is compared with values worked out from the frame
// timing rules (pulse offset, byte, hold of P_DATA on errors).
module tb_uart_rx;

    localparam int PW = 6;

    logic          CLK_tb = 1'b0;
    logic          RST_tb;
    logic [PW-1:0] prescale_tb;
    logic          rx_tb;
    logic          par_en_tb;
    logic          par_typ_tb;
    logic [7:0]    p_data_tb;
    logic          data_valid_tb;

    int         n_cmp       = 0;
    int         n_bad       = 0;
    int         cyc         = 0;
    int         pulse_total = 0;
    logic [7:0] last_good   = 8'h00;

    uart_rx #(.PRESCALE_WIDTH(PW)) dut (
        .CLK        (CLK_tb),
        .RST        (RST_tb),
        .Prescale   (prescale_tb),
        .RX_IN      (rx_tb),
        .PAR_EN     (par_en_tb),
        .PAR_TYP    (par_typ_tb),
        .P_DATA     (p_data_tb),
        .data_valid (data_valid_tb)
    );

    always #5 CLK_tb = ~CLK_tb;

    always @(posedge CLK_tb) cyc <= cyc + 1;

    always @(negedge CLK_tb) if (data_valid_tb === 1'b1) pulse_total <= pulse_total + 1;

    // Cycles from the first low cycle of the start bit to the data_valid cycle.
    function automatic int exp_off(input bit pe, input int p);
        return (9 + int'(pe)) * p + p / 2 + 3;
    endfunction

    task automatic step();
        @(posedge CLK_tb);
        #2;
    endtask

    task automatic idle(input int n);
        rx_tb = 1'b1;
        repeat (n) step();
    endtask

    task automatic set_cfg(input int p, input bit pe, input bit pt);
        prescale_tb = PW'(p);
        par_en_tb   = pe;
        par_typ_tb  = pt;
    endtask

    // Drives one frame with the current configuration. glitch_bit selects a bit whose
    // middle cycle is inverted (-1 for none). Reports pulses seen during the frame.
    task automatic drive_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                               input int glitch_bit, output int n_pulse,
                               output int pulse_off, output logic [7:0] pdata_seen);
        logic bits [0:10];
        int   nb;
        int   p;
        int   t_start;
        p = int'(prescale_tb);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i + 1] = d[i];
        nb = 9;
        if (par_en_tb) begin
            bits[9] = (par_typ_tb ? ~(^d) : ^d) ^ bad_par;
            nb = 10;
        end
        bits[nb] = ~bad_stop;
        nb = nb + 1;
        n_pulse    = 0;
        pulse_off  = -1;
        pdata_seen = 8'h00;
        t_start    = cyc;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < p; j++) begin
                rx_tb = (b == glitch_bit && j == p / 2) ? ~bits[b] : bits[b];
                @(negedge CLK_tb);
                if (data_valid_tb === 1'b1) begin
                    n_pulse = n_pulse + 1;
                    if (pulse_off < 0) pulse_off = cyc - t_start;
                    pdata_seen = p_data_tb;
                end
                step();
            end
        end
        rx_tb = 1'b1;
    endtask

    task automatic test_reset();
        RST_tb = 1'b0;
        rx_tb  = 1'b1;
        set_cfg(8, 0, 0);
        repeat (2) @(negedge CLK_tb);
        n_cmp++;
        if (p_data_tb !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_p_data: got %h want 00", p_data_tb);
        end
        n_cmp++;
        if (data_valid_tb !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_data_valid: got %b want 0", data_valid_tb);
        end
        step();
        RST_tb = 1'b1;
        idle(3);
        n_cmp++;
        if (p_data_tb !== 8'h00 || data_valid_tb !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset_idle: got p_data=%h dv=%b want 00/0", p_data_tb,
                     data_valid_tb);
        end
    endtask

    task automatic test_b2b(input string name, input int p, input bit pe, input bit pt,
                            input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2);
        logic [7:0] frames [3];
        int         np;
        int         off;
        logic [7:0] pd;
        frames[0] = f0;
        frames[1] = f1;
        frames[2] = f2;
        set_cfg(p, pe, pt);
        for (int i = 0; i < 3; i++) begin
            drive_frame(frames[i], 1'b0, 1'b0, -1, np, off, pd);
            n_cmp++;
            if (np !== 1 || off !== exp_off(pe, p)) begin
                n_bad++;
                $display("FAIL %s_timing[%0d]: got pulses=%0d offset=%0d want 1/%0d", name,
                         i, np, off, exp_off(pe, p));
            end
            n_cmp++;
            if (pd !== frames[i]) begin
                n_bad++;
                $display("FAIL %s_data[%0d]: got %h want %h", name, i, pd, frames[i]);
            end
        end
        last_good = frames[2];
        idle(4);
    endtask

    task automatic test_glitch();
        int         pt0;
        int         np;
        int         off;
        logic [7:0] pd;
        set_cfg(8, 0, 0);
        pt0   = pulse_total;
        rx_tb = 1'b0;
        step();
        idle(6);
        n_cmp++;
        if (pulse_total !== pt0) begin
            n_bad++;
            $display("FAIL glitch_no_pulse: got %0d pulses want 0", pulse_total - pt0);
        end
        drive_frame(8'h51, 1'b0, 1'b0, -1, np, off, pd);
        n_cmp++;
        if (np !== 1 || off !== exp_off(1'b0, 8) || pd !== 8'h51) begin
            n_bad++;
            $display("FAIL glitch_recover: got pulses=%0d offset=%0d data=%h want 1/%0d/51",
                     np, off, pd, exp_off(1'b0, 8));
        end
        last_good = 8'h51;
        idle(4);
    endtask

    task automatic test_frame_errors();
        int         np;
        int         off;
        logic [7:0] pd;
        int         pt0;
        set_cfg(8, 1, 1);
        drive_frame(8'hB7, 1'b1, 1'b0, -1, np, off, pd);
        n_cmp++;
        if (np !== 0 || p_data_tb !== last_good) begin
            n_bad++;
            $display("FAIL parity_error: got pulses=%0d p_data=%h want 0/%h", np, p_data_tb,
                     last_good);
        end
        idle(4);
        set_cfg(8, 0, 0);
        pt0 = pulse_total;
        drive_frame(8'hAA, 1'b0, 1'b1, -1, np, off, pd);
        idle(12);
        n_cmp++;
        if (np !== 0 || pulse_total !== pt0 || p_data_tb !== last_good) begin
            n_bad++;
            $display("FAIL stop_error: got pulses=%0d p_data=%h want 0/%h",
                     pulse_total - pt0, p_data_tb, last_good);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int         np;
        int         off;
        logic [7:0] pd;
        set_cfg(8, 0, 0);
        d = 8'h3C;
        for (int i = 0; i < 32; i++) begin
            rx_tb = (i < 8) ? 1'b0 : d[(i - 8) / 8];
            step();
        end
        RST_tb = 1'b0;
        #1;
        n_cmp++;
        if (p_data_tb !== 8'h00 || data_valid_tb !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_frame: got p_data=%h dv=%b want 00/0", p_data_tb,
                     data_valid_tb);
        end
        step();
        rx_tb  = 1'b1;
        RST_tb = 1'b1;
        idle(4);
        drive_frame(8'h96, 1'b0, 1'b0, -1, np, off, pd);
        n_cmp++;
        if (np !== 1 || off !== exp_off(1'b0, 8) || pd !== 8'h96) begin
            n_bad++;
            $display("FAIL after_reset_frame: got pulses=%0d offset=%0d data=%h want 1/%0d/96",
                     np, off, pd, exp_off(1'b0, 8));
        end
        last_good = 8'h96;
        idle(4);
    endtask

    task automatic test_random();
        int         p;
        bit         pe;
        bit         pt;
        logic [7:0] d;
        int         err;
        bit         bad_par;
        bit         bad_stop;
        bit         good;
        int         gbit;
        int         np;
        int         off;
        logic [7:0] pd;
        int         exp_pulses;
        int         pt0;
        pt0        = pulse_total;
        exp_pulses = 0;
        for (int n = 0; n < 40; n++) begin
            p        = 2 * int'($urandom_range(4, 16));
            pe       = 1'($urandom_range(0, 1));
            pt       = 1'($urandom_range(0, 1));
            d        = 8'($urandom);
            err      = int'($urandom_range(0, 9));
            bad_par  = pe && (err == 0);
            bad_stop = (err == 1);
            good     = !bad_par && !bad_stop;
            gbit     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
            set_cfg(p, pe, pt);
            drive_frame(d, bad_par, bad_stop, gbit, np, off, pd);
            if (good) begin
                exp_pulses = exp_pulses + 1;
                last_good  = d;
                n_cmp++;
                if (np !== 1 || off !== exp_off(pe, p) || pd !== d) begin
                    n_bad++;
                    $display("FAIL random[%0d] p=%0d pe=%0b pt=%0b glitch=%0d: got pulses=%0d offset=%0d data=%h want 1/%0d/%h",
                             n, p, pe, pt, gbit, np, off, pd, exp_off(pe, p), d);
                end
            end else begin
                n_cmp++;
                if (np !== 0 || p_data_tb !== last_good) begin
                    n_bad++;
                    $display("FAIL random_err[%0d] par=%0b stop=%0b: got pulses=%0d p_data=%h want 0/%h",
                             n, bad_par, bad_stop, np, p_data_tb, last_good);
                end
            end
            if (bad_stop) idle(p);
            else if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, p)));
        end
        idle(40);
        n_cmp++;
        if (pulse_total - pt0 !== exp_pulses) begin
            n_bad++;
            $display("FAIL random_pulse_total: got %0d want %0d", pulse_total - pt0,
                     exp_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_b2b("even_b2b", 8, 1'b1, 1'b0, 8'hC1, 8'hFC, 8'hAA);
        test_b2b("odd_b2b", 16, 1'b1, 1'b1, 8'h2D, 8'hB7, 8'hC1);
        test_b2b("no_parity", 32, 1'b0, 1'b0, 8'hB7, 8'hAA, 8'h2D);
        test_glitch();
        test_frame_errors();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
